weight_stream_reader: RTL and testbench

WEIGHT_STREAM_READER -- requirements
Module: weight_stream_reader

---
 rtl/weight_stream_reader_pkg.sv | 19 +
 rtl/weight_stream_reader_if.sv | 20 ++
 rtl/weight_skid_fifo.sv | 58 +++++
 rtl/weight_stream_reader.sv | 120 ++++++++++++
 tb/tb_weight_stream_reader.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_stream_reader_pkg.sv
// Shared definitions for the weight stream reader.
//   DW_DEFAULT    : weight word width
//   AW_DEFAULT    : weight memory address width
//   DEPTH_DEFAULT : number of weight words streamed per fetch
//   state_t       : reader FSM state encoding
package weight_stream_reader_pkg;

    localparam int DW_DEFAULT    = 16;
    localparam int AW_DEFAULT    = 5;
    localparam int DEPTH_DEFAULT = 28;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/weight_stream_reader_if.sv
// Weight word stream (valid/ready) between the reader and its consumer.
//   w_data  : streamed weight word
//   w_valid : w_data holds a word
//   w_ready : consumer accepts the word this cycle
//   w_last  : word came from the final address of the fetch
// master = reader side, slave = consumer side.
interface weight_stream_reader_if
    import weight_stream_reader_pkg::*;
#(
    parameter int DW = DW_DEFAULT
);
    logic [DW-1:0] w_data;
    logic          w_valid;
    logic          w_ready;
    logic          w_last;

    modport master (output w_data, output w_valid, output w_last, input w_ready);
    modport slave  (input w_data, input w_valid, input w_last, output w_ready);

endinterface

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO holding captured BRAM words plus their last flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data this cycle (caller guarantees not full)
//   push_data  : word to store
//   pop        : drop the head entry this cycle (caller guarantees not empty)
//   head       : oldest entry
//   valid      : FIFO holds at least one entry
//   count      : current occupancy (0..2)
module weight_skid_fifo #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    // NOTE: the storage is reset because the head entry drives the stream
    // data output directly and that output must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments let push and pop in the same cycle
            // both see the pre-edge pointers, so occupancy stays put and the
            // head is replaced without losing the incoming word.
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != 2'd0);

endmodule

// File: rtl/weight_stream_reader.sv
// Streams DEPTH weight words out of a read-only BRAM onto a valid/ready
// stream, one word per cycle when the consumer never stalls.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle request to stream all DEPTH words (ignored when busy)
//   bram_addr  : registered BRAM read address
//   bram_en    : registered BRAM read enable
//   bram_we    : BRAM write enable, tied low
//   bram_do    : BRAM read data, valid at the rising edge ending the read cycle
//   w_if       : weight word stream (master side)
//   busy       : fetch in progress, from start acceptance until done
//   done       : one-cycle pulse after the final word has been accepted
module weight_stream_reader
    import weight_stream_reader_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int AW    = AW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] bram_addr,
    output logic          bram_en,
    output logic          bram_we,
    input  logic [DW-1:0] bram_do,
    weight_stream_reader_if.master w_if,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] addr_cnt;

    logic [DW:0]   fifo_head;
    logic          fifo_valid;
    logic [1:0]    fifo_count;
    logic          push;
    logic          push_last;
    logic          pop;
    logic [2:0]    occ_after;
    logic          issue;

    // The read issued last cycle (bram_en high) lands in the FIFO at this edge.
    assign push      = bram_en;
    assign push_last = (bram_addr == LAST_ADDR);
    assign pop       = fifo_valid & w_if.w_ready;

    // Buffered plus in-flight words once this edge's push and pop settle; a new
    // read is only launched while that leaves room for its data.
    assign occ_after = {1'b0, fifo_count} + {2'b00, push} - {2'b00, pop};
    assign issue     = (state == ST_FETCH) && (occ_after < 3'd2);

    weight_skid_fifo #(
        .W (DW + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({push_last, bram_do}),
        .pop       (pop),
        .head      (fifo_head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            addr_cnt  <= '0;
            bram_addr <= '0;
            bram_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            bram_en <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        addr_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (issue) begin
                        bram_en   <= 1'b1;
                        bram_addr <= addr_cnt;
                        // The counter parks on the last address instead of wrapping.
                        if (addr_cnt == LAST_ADDR) begin
                            state <= ST_DRAIN;
                        end else begin
                            addr_cnt <= addr_cnt + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && fifo_head[DW]) begin
                        state <= ST_FINISH;
                        done  <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bram_we     = 1'b0;
    assign w_if.w_data  = fifo_head[DW-1:0];
    assign w_if.w_valid = fifo_valid;
    // Gate with valid so a stale last flag in an empty FIFO never shows.
    assign w_if.w_last  = fifo_head[DW] & fifo_valid;

endmodule

// File: tb/tb_weight_stream_reader.sv
module tb_weight_stream_reader;
    import weight_stream_reader_pkg::*;

    localparam int DW    = DW_DEFAULT;
    localparam int AW    = AW_DEFAULT;
    localparam int DEPTH = DEPTH_DEFAULT;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic          bram_we;
    logic [DW-1:0] bram_do = '0;
    logic          busy;
    logic          done;

    weight_stream_reader_if #(.DW(DW)) w_if ();

    weight_stream_reader #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bram_addr (bram_addr),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_do   (bram_do),
        .w_if      (w_if),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // BRAM model: word i holds 16'h0100 + i, data out changes on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (bram_en) bram_do = 16'h0100 + 16'(bram_addr);
        end
    end

    // Consumer ready pattern: 0 = always, 1 = toggle, 2 = random, 3 = stalled.
    int ready_mode = 0;
    initial begin
        w_if.w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       w_if.w_ready = 1'b1;
                1:       w_if.w_ready = ~w_if.w_ready;
                2:       w_if.w_ready = 1'($urandom_range(0, 1));
                default: w_if.w_ready = 1'b0;
            endcase
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state: expected words in order, plus stream bookkeeping.
    logic [DW:0] exp_q[$];
    logic [DW:0] exp_word;
    logic [DW:0] held_word;
    logic        exp_done   = 1'b0;
    logic        stall_prev = 1'b0;
    bit          model_busy = 1'b0;
    int cyc = 0, n_reads = 0, n_xfer = 0, done_cnt = 0, max_occ = 0;
    int occ_now, first_cyc = 0, last_cyc = 0, we_bad = 0;

    // Monitor: samples on the falling edge, pops the scoreboard on each transfer.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bram_we !== 1'b0) we_bad++;
            if (rst_n) begin
                if (done || exp_done) check("done_pulse", done, exp_done);
                if (done) done_cnt++;
                exp_done = 1'b0;
                check("valid_vs_buffered", w_if.w_valid, (n_reads - n_xfer) > 0);
                occ_now = n_reads - n_xfer + (bram_en ? 1 : 0);
                if (occ_now > max_occ) max_occ = occ_now;
                if (bram_en) n_reads++;
                if (stall_prev)
                    check("stall_hold", {w_if.w_valid, w_if.w_last, w_if.w_data}, {1'b1, held_word});
                if (w_if.w_valid && w_if.w_ready) begin
                    check("word_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        exp_word = exp_q.pop_front();
                        check("stream_word", {w_if.w_last, w_if.w_data}, exp_word);
                        exp_done = exp_word[DW];
                    end
                    if (n_xfer == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    n_xfer++;
                end
                stall_prev = w_if.w_valid && !w_if.w_ready;
                held_word  = {w_if.w_last, w_if.w_data};
            end
        end
    end

    // Stimulus acts 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_stats();
        n_reads  = 0;
        n_xfer   = 0;
        done_cnt = 0;
        max_occ  = 0;
    endtask

    task automatic start_stream();
        start = 1'b1;
        if (!model_busy) begin
            for (int i = 0; i < DEPTH; i++)
                exp_q.push_back({i == DEPTH - 1, 16'h0100 + 16'(i)});
            model_busy = 1'b1;
        end
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic run_and_wait(input string tag);
        bit timed_out = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (done_cnt > 0 && exp_q.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        check({tag, "_timeout"}, timed_out, 1'b0);
        check({tag, "_busy_low"}, busy, 1'b0);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_words"}, n_xfer, DEPTH);
        check({tag, "_occupancy_le2"}, max_occ <= 2, 1'b1);
        model_busy = 1'b0;
    endtask

    task automatic wait_words(input int n, input string tag);
        bit timed_out = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (n_xfer >= n) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        check({tag, "_reach_word"}, timed_out, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bram_addr"}, bram_addr, 0);
        check({tag, "_bram_en"}, bram_en, 0);
        check({tag, "_bram_we"}, bram_we, 0);
        check({tag, "_w_data"}, w_if.w_data, 0);
        check({tag, "_w_valid"}, w_if.w_valid, 0);
        check({tag, "_w_last"}, w_if.w_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // Full throughput with the consumer always ready.
        clear_stats();
        ready_mode = 0;
        start_stream();
        run_and_wait("full_rate");
        check("full_rate_consecutive", last_cyc - first_cyc, DEPTH - 1);
        repeat (3) tick();

        // Consumer ready toggling every cycle.
        clear_stats();
        ready_mode = 1;
        start_stream();
        run_and_wait("toggle");
        repeat (3) tick();

        // Consumer stalled for 10 cycles after start: only two reads may go out.
        clear_stats();
        ready_mode = 3;
        start_stream();
        repeat (10) tick();
        check("stall_reads", n_reads, 2);
        check("stall_valid", w_if.w_valid, 1'b1);
        ready_mode = 0;
        run_and_wait("stall");
        repeat (3) tick();

        // A second start in the middle of a stream is ignored.
        clear_stats();
        ready_mode = 2;
        start_stream();
        wait_words(5, "restart");
        start_stream();
        run_and_wait("restart");
        repeat (40) tick();
        check("restart_single_done", done_cnt, 1);

        // Reset in the middle of a stream aborts it without a done pulse.
        clear_stats();
        ready_mode = 0;
        start_stream();
        wait_words(12, "abort");
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        exp_done   = 1'b0;
        stall_prev = 1'b0;
        model_busy = 1'b0;
        clear_stats();
        repeat (3) tick();
        check("abort_done_in_reset", done, 1'b0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", busy, 1'b0);
        clear_stats();
        ready_mode = 2;
        start_stream();
        run_and_wait("after_abort");
        repeat (3) tick();

        // A couple more streams under random backpressure.
        for (int s = 0; s < 2; s++) begin
            clear_stats();
            ready_mode = 2;
            start_stream();
            run_and_wait("random");
            repeat (2) tick();
        end

        check("bram_we_never_high", we_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
